// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with grant hold,
// release handshake (done) and an optional hold timeout.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   level-sensitive request lines, bit i = requester i
//   done       owner release strobe, sampled while a grant is held
//   grant[3:0] registered grant, all-zero or one-hot
//   gnt_valid  registered, high exactly when grant is non-zero
//   timeout    registered one-cycle pulse when a grant is revoked by timeout
//
// Parameter TIMEOUT (0..255): max hold cycles without done; 0 disables.
module rr_arbiter4 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned N_REQ   = 4;
  localparam bit          TO_EN   = (TIMEOUT != 0);
  // Last counter value before the timeout fires; unused when disabled.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   idx;
  logic               to_hit;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    found       = 1'b0;
    win         = ptr_q;
    idx         = ptr_q;
    to_hit      = TO_EN && (cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        // Rotating priority scan starting at ptr; first set bit wins.
        for (int i = 0; i < N_REQ; i++) begin
          idx = ptr_q + IDX_W'(i);
          if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          grant_d     = N_REQ'(1) << win;
          gnt_valid_d = 1'b1;
          owner_d     = win;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Saturate so a disabled timeout never lets the counter wrap.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done || to_hit) begin
          grant_d     = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = owner_q + IDX_W'(1);
          cnt_d       = '0;
          timeout_d   = !done;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4 with TIMEOUT = 4.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       gnt_valid;
  logic       timeout;

  int tests;
  int fails;

  rr_arbiter4 #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #3;
    tests++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_asserted: grant=%b gnt_valid=%b timeout=%b, want 0000/0/0",
               grant, gnt_valid, timeout);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (grant !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        fails++;
        $display("FAIL idle_cycle%0d: grant=%b gnt_valid=%b timeout=%b, want 0000/0/0",
                 i, grant, gnt_valid, timeout);
      end
    end
  endtask

  task automatic test_single_requester();
    req  = 4'b0100;
    done = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++;
      if (grant !== 4'b0100 || gnt_valid !== 1'b1) begin
        fails++;
        $display("FAIL single_grant_c%0d: grant=%b gnt_valid=%b, want 0100/1", c, grant, gnt_valid);
      end
      if (c == 3) done = 1'b1;
    end
    tick();
    done = 1'b0;
    tests++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL single_release: grant=%b gnt_valid=%b timeout=%b, want 0000/0/0",
               grant, gnt_valid, timeout);
    end
    req = 4'b0000;
    tick();
    tests++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL single_gap: grant=%b, want 0000", grant);
    end
  endtask

  // ptr is 3 after requester 2 released, so the first 1111 winner is 1000.
  task automatic test_round_robin();
    logic [3:0] exp_seq [6];
    exp_seq[0] = 4'b1000;
    exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0100;
    exp_seq[4] = 4'b1000;
    exp_seq[5] = 4'b0001;
    req  = 4'b1111;
    done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (grant !== exp_seq[i] || gnt_valid !== 1'b1) begin
        fails++;
        $display("FAIL rr_grant%0d: grant=%b gnt_valid=%b, want %b/1", i, grant, gnt_valid, exp_seq[i]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      if (i == 5) req = 4'b0000;
      tests++;
      if (grant !== 4'b0000 || gnt_valid !== 1'b0) begin
        fails++;
        $display("FAIL rr_gap%0d: grant=%b gnt_valid=%b, want 0000/0", i, grant, gnt_valid);
      end
    end
  endtask

  // ptr is 1 here; requester 1 wins and is revoked after 4 cycles.
  task automatic test_timeout();
    req  = 4'b0010;
    done = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests++;
      if (grant !== 4'b0010 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
        fails++;
        $display("FAIL to_hold_c%0d: grant=%b gnt_valid=%b timeout=%b, want 0010/1/0",
                 c, grant, gnt_valid, timeout);
      end
    end
    tick();
    req = 4'b1010;
    tests++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL to_fire: grant=%b gnt_valid=%b timeout=%b, want 0000/0/1",
               grant, gnt_valid, timeout);
    end
    tick();
    tests++;
    if (grant !== 4'b1000 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL to_next_winner: grant=%b gnt_valid=%b timeout=%b, want 1000/1/0",
               grant, gnt_valid, timeout);
    end
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    tests++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL to_done_release: grant=%b timeout=%b, want 0000/0", grant, timeout);
    end
  endtask

  // done on the same edge the timeout would fire: no timeout pulse.
  task automatic test_done_vs_timeout();
    req  = 4'b0010;
    done = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests++;
      if (grant !== 4'b0010) begin
        fails++;
        $display("FAIL dvt_hold_c%0d: grant=%b, want 0010", c, grant);
      end
      if (c == 4) done = 1'b1;
    end
    tick();
    done = 1'b0;
    req  = 4'b0000;
    tests++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL dvt_release: grant=%b gnt_valid=%b timeout=%b, want 0000/0/0",
               grant, gnt_valid, timeout);
    end
    tick();
    tests++;
    if (timeout !== 1'b0 || grant !== 4'b0000) begin
      fails++;
      $display("FAIL dvt_after: grant=%b timeout=%b, want 0000/0", grant, timeout);
    end
  endtask

  // ptr is 2; requester 3 wins, then reset lands between edges.
  task automatic test_async_reset();
    req  = 4'b1000;
    done = 1'b0;
    tick();
    tests++;
    if (grant !== 4'b1000 || gnt_valid !== 1'b1) begin
      fails++;
      $display("FAIL ar_grant: grant=%b gnt_valid=%b, want 1000/1", grant, gnt_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL ar_immediate: grant=%b gnt_valid=%b timeout=%b, want 0000/0/0",
               grant, gnt_valid, timeout);
    end
    tick();
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    tests++;
    if (grant !== 4'b0001 || gnt_valid !== 1'b1) begin
      fails++;
      $display("FAIL ar_ptr_reset: grant=%b gnt_valid=%b, want 0001/1", grant, gnt_valid);
    end
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_timeout();
    test_done_vs_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
